module_antirebote_gray: RTL and testbench
=========================================

MODULE_ANTIREBOTE_GRAY -- requirements
Module: module_antirebote_gray

Interface
REQ-001 Parameter WIDTH, default 4, width of the Gray input vector.
REQ-002 Parameter STABLE_CYCLES, default 270000, number of clk_i cycles a new input value must stay stable before it is accepted (10 ms at 27 MHz); legal range 2 or more.
REQ-003 clk_i  input  1  single system clock; all logic on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous and active-high.
REQ-005 gray_raw_i  input  WIDTH  raw, asynchronous, bouncing switch vector.
REQ-006 gray_o  output  WIDTH  debounced Gray code; feeds the Gray reader/decoder stage downstream.
REQ-007 cambio_o  output  1  one-cycle pulse when gray_o takes a new value.
REQ-008 salto_o  output  1  one-cycle pulse, coincident with cambio_o, when the accepted value differs from the previous gray_o in more than one bit (illegal Gray step).
REQ-009 busy_o  output  1  high while a candidate value is being qualified.

Function
REQ-010 Two-flop synchronizer on gray_raw_i; only the synchronized vector (sync_q) is used downstream of it.
REQ-011 FSM states: IDLE, COUNT, COMMIT.
REQ-012 IDLE: if sync_q equals gray_o, stay; else latch candidate from sync_q, clear counter, go to COUNT.
REQ-013 COUNT: if sync_q differs from the candidate, reload candidate from sync_q and clear counter; stay in COUNT.
REQ-014 COUNT: if sync_q equals gray_o, abort to IDLE with no output change (glitch rejected).
REQ-015 COUNT: otherwise increment counter; when counter reaches STABLE_CYCLES-1, go to COMMIT.
REQ-016 COMMIT: gray_o loads the candidate; cambio_o is 1 for exactly this cycle; salto_o is 1 if popcount(candidate XOR old gray_o) > 1; next state IDLE.
REQ-017 Latency: raw input constant from edge k gives gray_o updated at edge k+3+STABLE_CYCLES (2 synchronizer cycles, 1 IDLE cycle, STABLE_CYCLES COUNT cycles); cambio_o is high in the cycle following the COMMIT decision.
REQ-018 The counter is $clog2(STABLE_CYCLES) bits, never wraps, and saturates only through the state transition.
REQ-019 busy_o is 1 in COUNT and COMMIT, 0 in IDLE.
REQ-020 Continuous bouncing faster than STABLE_CYCLES holds the FSM in COUNT indefinitely; gray_o is held unchanged.
REQ-021 cambio_o and salto_o are never 1 outside COMMIT, and are never high for two consecutive cycles.

Reset
REQ-022 rst_i, synchronous active-high, sets the synchronizer flops, candidate, counter and gray_o to 0, cambio_o, salto_o and busy_o to 0, and the state to IDLE.
REQ-023 Reset asserted mid-COUNT or in COMMIT discards the candidate with no cambio_o pulse; rst_i has priority over every other input.
REQ-024 After release, a nonzero raw input is qualified normally and produces one cambio_o pulse.

Structure
REQ-025 State encodings (IDLE=2'd0, COUNT=2'd1, COMMIT=2'd2) and the default STABLE_CYCLES are defined in the shared project package.
REQ-026 The two-flop synchronizer is a separate sub-module, module_sincronizador, parameterized by WIDTH.
REQ-027 popcount for salto_o is purely combinational inside the block; no latches; each output is driven from a register.

Verification (STABLE_CYCLES=4 for simulation)
REQ-028 Reset, then raw=4'b0000 held -> gray_o=0, cambio_o never asserts, busy_o=0.
REQ-029 raw 0000->0001 held from edge k -> gray_o=0001 at edge k+7, single cambio_o pulse, salto_o=0.
REQ-030 raw pulses 0001 for 2 cycles, then back to 0000 -> gray_o stays 0000, no cambio_o, busy_o returns to 0.
REQ-031 raw toggles 0011/0010 every 3 cycles for 50 cycles, then holds 0010 -> gray_o stays put until 0010 has been stable for 4 COUNT cycles, then one pulse.
REQ-032 gray_o=0000 and raw jumps to 0110 -> gray_o=0110, with cambio_o and salto_o both pulsed.
REQ-033 rst_i asserted for 1 cycle in mid-COUNT -> gray_o=0 and no pulse; the held raw value is then re-qualified, giving one pulse 7 cycles after release.

Source files
------------

// File: rtl/module_antirebote_gray_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : module_antirebote_gray_pkg                                    |
// | Purpose    : Shared definitions for the Gray-code debouncer: FSM state     |
// |              encodings and the default qualification time.                 |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package module_antirebote_gray_pkg;

  // Default qualification time: 10 ms at a 27 MHz system clock.
  localparam int DEFAULT_STABLE_CYCLES = 270000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COUNT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/module_antirebote_gray_sincronizador.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : module_sincronizador                                          |
// | Purpose    : Two-flop synchronizer bringing an asynchronous vector into    |
// |              the clk_i domain.                                             |
// | Ports      : clk_i   - system clock (rising edge)                          |
// |              rst_i   - synchronous active-high reset, clears both stages   |
// |              async_i - asynchronous input vector                           |
// |              sync_o  - synchronized vector (second flop stage)             |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module module_sincronizador #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  // First stage may go metastable; only the second stage is used downstream.
  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta   <= '0;
      sync_o <= '0;
    end else begin
      meta   <= async_i;
      sync_o <= meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/module_antirebote_gray.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : module_antirebote_gray                                        |
// | Purpose    : Debouncer for a Gray-coded switch vector. A new value must    |
// |              stay stable for STABLE_CYCLES clocks before it is accepted;   |
// |              acceptance pulses cambio_o, and salto_o flags an accepted     |
// |              step that changes more than one bit (illegal Gray step).      |
// | Ports      : clk_i      - system clock (rising edge)                       |
// |              rst_i      - synchronous active-high reset                    |
// |              gray_raw_i - raw, asynchronous, bouncing switch vector        |
// |              gray_o     - debounced Gray code                              |
// |              cambio_o   - one-cycle pulse when gray_o takes a new value    |
// |              salto_o    - one-cycle pulse with cambio_o on a multi-bit step|
// |              busy_o     - high while a candidate value is being qualified  |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module module_antirebote_gray
  import module_antirebote_gray_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] gray_raw_i,
  output logic [WIDTH-1:0] gray_o,
  output logic             cambio_o,
  output logic             salto_o,
  output logic             busy_o
);

  localparam int               CNT_W    = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam int               POP_W    = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] sync_q;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] cand;
  logic [WIDTH-1:0] cand_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [WIDTH-1:0] gray_next;
  logic             cambio_next;
  logic             salto_next;
  logic             busy_next;
  logic [WIDTH-1:0] diff;
  logic [POP_W-1:0] ones;

  module_sincronizador #(
    .WIDTH (WIDTH)
  ) u_sincronizador (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .async_i (gray_raw_i),
    .sync_o  (sync_q)
  );

  // Number of bits that change between the accepted value and the candidate.
  always_comb begin
    diff = cand ^ gray_o;
    ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + POP_W'(diff[i]);
    end
  end

  always_comb begin
    state_next  = state;
    cand_next   = cand;
    cnt_next    = cnt;
    gray_next   = gray_o;
    cambio_next = 1'b0;
    salto_next  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (sync_q != gray_o) begin
          cand_next  = sync_q;
          cnt_next   = '0;
          state_next = ST_COUNT;
        end
      end

      ST_COUNT: begin
        if (sync_q != cand) begin
          // Input moved again: restart qualification on the new value.
          cand_next = sync_q;
          cnt_next  = '0;
        end else if (sync_q == gray_o) begin
          // Input settled back on the accepted value: glitch rejected.
          state_next = ST_IDLE;
        end else if (cnt == CNT_LAST) begin
          // Counter never wraps: the last count leaves COUNT instead.
          state_next = ST_COMMIT;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end

      ST_COMMIT: begin
        gray_next   = cand;
        cambio_next = 1'b1;
        salto_next  = (ones > POP_W'(1));
        state_next  = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Registered from the next state so busy_o tracks the current state exactly.
    busy_next = (state_next != ST_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      cand     <= '0;
      cnt      <= '0;
      gray_o   <= '0;
      cambio_o <= 1'b0;
      salto_o  <= 1'b0;
      busy_o   <= 1'b0;
    end else begin
      state    <= state_next;
      cand     <= cand_next;
      cnt      <= cnt_next;
      gray_o   <= gray_next;
      cambio_o <= cambio_next;
      salto_o  <= salto_next;
      busy_o   <= busy_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_module_antirebote_gray.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module     : tb_module_antirebote_gray                                     |
// | Purpose    : Scoreboard testbench for module_antirebote_gray with          |
// |              STABLE_CYCLES=4. Stimulus pushes expected commits; a monitor  |
// |              pops one on every cambio_o and checks hold behaviour between. |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_module_antirebote_gray;

  localparam int WIDTH = 4;
  localparam int S     = 4;
  // Raw driven at a negedge with cyc=c is first sampled at edge c+1;
  // gray_o updates at that edge + 3 + S.
  localparam int LAT   = 1 + 3 + S;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] raw = '0;
  logic [WIDTH-1:0] gray;
  logic             cambio;
  logic             salto;
  logic             busy;

  module_antirebote_gray #(
    .WIDTH         (WIDTH),
    .STABLE_CYCLES (S)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .gray_raw_i (raw),
    .gray_o     (gray),
    .cambio_o   (cambio),
    .salto_o    (salto),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int               cyc;
    logic [WIDTH-1:0] gray;
    logic             salto;
  } exp_t;

  exp_t             q[$];
  int               checks = 0;
  int               errors = 0;
  logic [WIDTH-1:0] exp_gray = '0;
  exp_t             e;
  logic             rst_s;

  // Monitor: every cycle either consume an expected commit or check that
  // the output is holding its last accepted value with no salto_o.
  initial begin : monitor
    forever begin
      @(posedge clk);
      rst_s = rst;
      #1;
      if (rst_s) exp_gray = '0;
      if (cambio === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: cambio_o=1 gray_o=%b at cycle %0d, required no pulse", gray, cyc);
        end else begin
          e = q.pop_front();
          if (cyc != e.cyc || gray !== e.gray || salto !== e.salto) begin
            errors++;
            $display("FAIL commit: cycle %0d gray_o=%b salto_o=%b, required cycle %0d gray_o=%b salto_o=%b",
                     cyc, gray, salto, e.cyc, e.gray, e.salto);
          end
          exp_gray = e.gray;
        end
      end else begin
        checks++;
        if (gray !== exp_gray || salto !== 1'b0 || cambio !== 1'b0) begin
          errors++;
          $display("FAIL hold: cycle %0d gray_o=%b salto_o=%b cambio_o=%b, required gray_o=%b salto_o=0 cambio_o=0",
                   cyc, gray, salto, cambio, exp_gray);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  task automatic drive(input logic [WIDTH-1:0] v);
    @(negedge clk);
    raw = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called in the same negedge slot as the drive that starts the stable run.
  task automatic expect_commit(input logic [WIDTH-1:0] g, input logic s);
    q.push_back('{cyc: cyc + LAT, gray: g, salto: s});
  endtask

  initial begin : stimulus
    // Reset state
    idle(3);
    chk("reset_gray",   gray,             4'b0000);
    chk("reset_cambio", {3'b000, cambio}, 4'b0000);
    chk("reset_salto",  {3'b000, salto},  4'b0000);
    chk("reset_busy",   {3'b000, busy},   4'b0000);
    @(negedge clk);
    rst = 1'b0;

    // All-zero input held: nothing to qualify
    idle(20);
    chk("zero_gray", gray,           4'b0000);
    chk("zero_busy", {3'b000, busy}, 4'b0000);

    // Two-cycle glitch to 0001 is rejected
    drive(4'b0001);
    idle(1);
    drive(4'b0000);
    idle(1);
    chk("glitch_busy_high", {3'b000, busy}, 4'b0001);
    idle(10);
    chk("glitch_gray",     gray,           4'b0000);
    chk("glitch_busy_low", {3'b000, busy}, 4'b0000);

    // Legal single-bit step 0000 -> 0001
    drive(4'b0001);
    expect_commit(4'b0001, 1'b0);
    idle(12);
    chk("step_gray", gray,           4'b0001);
    chk("step_busy", {3'b000, busy}, 4'b0000);

    // Bouncing 0011/0010 every 3 cycles (never stable long enough), then 0010 held
    for (int i = 0; i < 17; i++) begin
      drive((i % 2 == 0) ? 4'b0011 : 4'b0010);
      idle(2);
    end
    chk("bounce_gray", gray,           4'b0001);
    chk("bounce_busy", {3'b000, busy}, 4'b0001);
    drive(4'b0010);
    expect_commit(4'b0010, 1'b1);  // 0001 -> 0010 changes two bits
    idle(14);
    chk("bounce_final_gray", gray, 4'b0010);

    // Back to 0000, then an illegal jump to 0110
    drive(4'b0000);
    expect_commit(4'b0000, 1'b0);
    idle(12);
    chk("return_zero_gray", gray, 4'b0000);
    drive(4'b0110);
    expect_commit(4'b0110, 1'b1);
    idle(12);
    chk("jump_gray", gray, 4'b0110);

    // Reset in mid-COUNT discards the candidate, then re-qualifies from 0
    drive(4'b0101);
    idle(4);
    chk("midcount_busy", {3'b000, busy}, 4'b0001);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("after_reset_gray",   gray,             4'b0000);
    chk("after_reset_busy",   {3'b000, busy},   4'b0000);
    chk("after_reset_cambio", {3'b000, cambio}, 4'b0000);
    expect_commit(4'b0101, 1'b1);  // 0000 -> 0101 changes two bits
    idle(14);
    chk("requalify_gray", gray,           4'b0101);
    chk("requalify_busy", {3'b000, busy}, 4'b0000);

    // Every expected commit must have been observed
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_commits: %0d pending, required 0 (first expected cycle %0d gray_o=%b)",
               q.size(), q[0].cyc, q[0].gray);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
